// File: rtl/tnn_pkg.sv
// Shared constants and types for the TNN feature packer: vector geometry,
// FSM state encoding and the feature-to-classifier-input letter mapping.
package tnn_pkg;

  localparam int N_FEAT = 7;
  localparam int FEAT_W = 2;

  typedef logic [1:0] tnn_state_t;

  localparam tnn_state_t ST_COLLECT  = 2'd0;
  localparam tnn_state_t ST_PRESENT  = 2'd1;
  localparam tnn_state_t ST_HOLD_RES = 2'd2;

  // Feature index carried to each classifier input letter.
  localparam int FEAT_A = 0;
  localparam int FEAT_B = 1;
  localparam int FEAT_C = 2;
  localparam int FEAT_D = 3;
  localparam int FEAT_E = 4;
  localparam int FEAT_F = 5;
  localparam int FEAT_G = 6;

endpackage

// File: rtl/tnn_feature_packer_if.sv
// Bundles the serial-feature, packed-vector and class-result handshakes
// of the feature packer; slave is the packer side, master its environment.
interface tnn_feature_packer_if #(
  parameter int N_FEAT = tnn_pkg::N_FEAT,
  parameter int FEAT_W = tnn_pkg::FEAT_W
);

  logic                       s_valid;
  logic                       s_ready;
  logic [FEAT_W-1:0]          s_data;
  logic                       s_last;
  logic                       vec_valid;
  logic                       vec_ready;
  logic [N_FEAT*FEAT_W-1:0]   vec_data;
  logic                       cls_in;
  logic                       res_valid;
  logic                       res_ready;
  logic                       res_class;
  logic                       err_frame;

  modport slave (
    input  s_valid, s_data, s_last, vec_ready, cls_in, res_ready,
    output s_ready, vec_valid, vec_data, res_valid, res_class, err_frame
  );

  modport master (
    output s_valid, s_data, s_last, vec_ready, cls_in, res_ready,
    input  s_ready, vec_valid, vec_data, res_valid, res_class, err_frame
  );

endinterface

// File: rtl/tnn_feature_packer_result_reg.sv
// Holds one class result from the classifier until the consumer takes it.
module tnn_result_reg (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic cls_i,
  input  logic res_ready_i,
  output logic res_valid_o,
  output logic res_class_o
);

  logic res_valid_q;
  logic res_class_q;

  // Capture on vector handshake; the packer never loads while a result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_class_q <= 1'b0;
    end else if (load_i) begin
      res_valid_q <= 1'b1;
      res_class_q <= cls_i;
    end else if (res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_class_o = res_class_q;

endmodule

// File: rtl/tnn_feature_packer.sv
// Packs serial quantized features into one vector for the classifier core and
// registers the returned class bit; collection of the next vector overlaps delivery.
module tnn_feature_packer #(
  parameter int N_FEAT = tnn_pkg::N_FEAT,
  parameter int FEAT_W = tnn_pkg::FEAT_W
) (
  input  logic                clk,
  input  logic                rst,
  tnn_feature_packer_if.slave bus
);

  import tnn_pkg::*;

  localparam int CNT_W = $clog2(N_FEAT + 1);
  localparam int VEC_W = N_FEAT * FEAT_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

  tnn_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0]  slots_q, slots_d;
  logic [VEC_W-1:0]  vec_data_q, vec_data_d;
  logic              vec_valid_q, vec_valid_d;
  logic              s_ready_q, s_ready_d;
  logic              err_q, err_d;

  logic [VEC_W-1:0]  slots_wr_s;
  logic              beat_s;
  logic              at_last_s;
  logic              complete_s;
  logic              frame_err_s;
  logic              vec_hs_s;
  logic              res_valid_s;
  logic              res_class_s;
  logic              res_gone_s;

  assign beat_s      = bus.s_valid & s_ready_q;
  assign at_last_s   = (cnt_q == LAST_IDX);
  assign complete_s  = beat_s & bus.s_last & at_last_s;
  assign frame_err_s = beat_s & (bus.s_last ^ at_last_s);
  assign vec_hs_s    = vec_valid_q & bus.vec_ready;
  // True when the result register will be empty on the next cycle.
  assign res_gone_s  = ~res_valid_s | bus.res_ready;

  // Slot array with the current beat written into slot cnt.
  always_comb begin
    slots_wr_s = slots_q;
    for (int k = 0; k < N_FEAT; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        slots_wr_s[k*FEAT_W +: FEAT_W] = bus.s_data;
      end else begin
        slots_wr_s[k*FEAT_W +: FEAT_W] = slots_q[k*FEAT_W +: FEAT_W];
      end
    end
  end

  // Collection counter, slots, presented vector and FSM next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slots_d     = slots_q;
    vec_data_d  = vec_data_q;
    vec_valid_d = vec_valid_q;
    err_d       = 1'b0;

    if (frame_err_s) begin
      cnt_d   = {CNT_W{1'b0}};
      slots_d = {VEC_W{1'b0}};
      err_d   = 1'b1;
    end else if (complete_s) begin
      cnt_d      = {CNT_W{1'b0}};
      slots_d    = {VEC_W{1'b0}};
      vec_data_d = slots_wr_s;
    end else if (beat_s) begin
      cnt_d   = cnt_q + CNT_W'(1);
      slots_d = slots_wr_s;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_COLLECT: begin
        if (complete_s) begin
          state_d     = ST_PRESENT;
          vec_valid_d = res_gone_s;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_PRESENT: begin
        if (vec_hs_s) begin
          state_d     = ST_HOLD_RES;
          vec_valid_d = 1'b0;
          vec_data_d  = {VEC_W{1'b0}};
        end else if (!vec_valid_q && res_gone_s) begin
          vec_valid_d = 1'b1;
        end else begin
          vec_valid_d = vec_valid_q;
        end
      end
      ST_HOLD_RES: begin
        // A completed vector waits unpresented until the held result drains.
        if (complete_s) begin
          state_d     = ST_PRESENT;
          vec_valid_d = res_gone_s;
        end else if (res_gone_s) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_HOLD_RES;
        end
      end
      default: begin
        state_d     = ST_COLLECT;
        cnt_d       = {CNT_W{1'b0}};
        slots_d     = {VEC_W{1'b0}};
        vec_data_d  = {VEC_W{1'b0}};
        vec_valid_d = 1'b0;
      end
    endcase

    s_ready_d = (state_d != ST_PRESENT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= {CNT_W{1'b0}};
      slots_q     <= {VEC_W{1'b0}};
      vec_data_q  <= {VEC_W{1'b0}};
      vec_valid_q <= 1'b0;
      s_ready_q   <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slots_q     <= slots_d;
      vec_data_q  <= vec_data_d;
      vec_valid_q <= vec_valid_d;
      s_ready_q   <= s_ready_d;
      err_q       <= err_d;
    end
  end

  tnn_result_reg u_result_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (vec_hs_s),
    .cls_i       (bus.cls_in),
    .res_ready_i (bus.res_ready),
    .res_valid_o (res_valid_s),
    .res_class_o (res_class_s)
  );

  assign bus.s_ready   = s_ready_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.vec_data  = vec_data_q;
  assign bus.res_valid = res_valid_s;
  assign bus.res_class = res_class_s;
  assign bus.err_frame = err_q;

endmodule

// File: doc/tnn_feature_packer.md
TNN_FEATURE_PACKER -- requirements
Module: tnn_feature_packer

Interface
REQ-001 Parameter N_FEAT, default 7: features per vector.
REQ-002 Parameter FEAT_W, default 2: bits per feature.
REQ-003 Port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port s_valid, input, 1: serial feature present on s_data.
REQ-006 Port s_ready, output, 1: packer accepts a serial feature this cycle.
REQ-007 Port s_data, input, FEAT_W: one quantized feature.
REQ-008 Port s_last, input, 1: marks the final feature of a vector.
REQ-009 Port vec_valid, output, 1: packed vector is stable on vec_data.
REQ-010 Port vec_ready, input, 1: classifier consumes the vector this cycle.
REQ-011 Port vec_data, output, N_FEAT*FEAT_W: feature k occupies bits [k*FEAT_W +: FEAT_W]; feature 0 maps to input_a, feature 6 to input_g.
REQ-012 Port cls_in, input, 1: combinational class bit returned by the classifier for vec_data.
REQ-013 Port res_valid, output, 1: a registered class result is available.
REQ-014 Port res_ready, input, 1: result consumer accepts it.
REQ-015 Port res_class, output, 1: registered class bit.
REQ-016 Port err_frame, output, 1: one-cycle pulse on a framing error.

Function
REQ-017 The FSM SHALL have states COLLECT, PRESENT, HOLD_RES.
REQ-018 COLLECT: s_ready=1; each s_valid&s_ready beat writes s_data to slot cnt and increments cnt (width clog2(N_FEAT+1)).
REQ-019 A beat with s_last=1 and cnt==N_FEAT-1 completes the vector: cnt->0, go to PRESENT.
REQ-020 A beat with s_last=1 and cnt<N_FEAT-1, or s_last=0 and cnt==N_FEAT-1, is a framing error: pulse err_frame next cycle, clear cnt and all slots, remain in COLLECT.
REQ-021 PRESENT: s_ready=0, vec_valid=1, vec_data held constant until handshake.
REQ-022 On vec_valid&vec_ready, cls_in SHALL be registered into res_class, res_valid set, state to HOLD_RES.
REQ-023 HOLD_RES: s_ready=1 (next vector collection overlaps result delivery); res_valid held until res_valid&res_ready.
REQ-024 If a next vector completes while res_valid is still 1, the FSM SHALL stay in PRESENT with vec_valid=0 until the result is consumed; no result is ever overwritten or dropped.
REQ-025 Result consumed with no pending complete vector: state to COLLECT.
REQ-026 Result handshake and completion of the next vector in the same cycle: go directly to PRESENT with vec_valid=1 next cycle.
REQ-027 Latency: final serial beat at cycle t -> vec_valid at t+1; vec handshake at t -> res_valid at t+1.
REQ-028 Throughput: one vector per N_FEAT+1 cycles when downstream always ready.
REQ-029 vec_data in COLLECT SHALL be all zeros (slots cleared on completion handshake), never partial.

Reset
REQ-030 rst=1 SHALL force state COLLECT, cnt=0, slots=0, vec_valid=0, res_valid=0, res_class=0, err_frame=0, s_ready=1 on the next edge, aborting any partial vector or pending result.
REQ-031 rst asserted mid-vector SHALL discard all accepted features; the first beat after release is feature 0.

Structure
REQ-032 N_FEAT, FEAT_W, the state enumeration type and the feature-to-letter index constants SHALL live in shared package tnn_pkg.
REQ-033 The result register and its valid/ready logic SHALL be sub-module tnn_result_reg; the FSM and slot array stay in the top.
REQ-034 The block SHALL contain no arithmetic on feature values; classification stays in the classifier core.

Verification
REQ-035 Features 1,2,3,0,1,2,3 with s_last on the 7th, vec_ready=1, cls_in=1 -> vec_data=14'b11_10_01_00_11_10_01 one cycle later, then res_valid=1, res_class=1.
REQ-036 s_last on the 4th beat -> err_frame pulses once, vec_valid never rises, the following 7-beat vector packs correctly.
REQ-037 vec_ready held 0 for 10 cycles -> vec_data stable, s_ready=0 throughout, no beat accepted.
REQ-038 res_ready=0 while a second vector completes -> vec_valid stays 0; releasing res_ready delivers the first result, then presents the second vector.
REQ-039 rst pulsed after 3 beats -> all outputs at reset values; next 7 beats form a clean vector starting at feature 0.
REQ-040 Back-to-back vectors, all ready signals held at 1 -> one res_valid every 8 cycles.
